// File: rtl/hline_move_ctrl.sv
// Sequencer for the horizontal-line position counter: emits UP/DW/LD pulses so the
// line bounces between its terminal positions at a frame-paced speed.
module hline_move_ctrl #(
  parameter logic [15:0] START_POS    = 16'd18,
  parameter int unsigned DWELL_FRAMES = 4,
  parameter int unsigned DIV_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             restart,
  input  logic [DIV_W-1:0] speed,
  input  logic [2:0]       step_px,
  input  logic             at_max,
  input  logic             at_min,
  output logic             UP,
  output logic             DW,
  output logic             LD,
  output logic [15:0]      load_val,
  output logic             dir,
  output logic             moving
);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DWELL = 3'd4;

  localparam int unsigned DWC_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DWC_W-1:0] DWELL_LAST =
    (DWELL_FRAMES == 0) ? '0 : DWC_W'(DWELL_FRAMES - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [DWC_W-1:0] dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic             up_q, up_d;
  logic             dw_q, dw_d;
  logic             ld_q, ld_d;
  logic             moving_q, moving_d;
  logic [15:0]      load_val_q, load_val_d;

  logic       limit;
  logic       issue;
  logic       hit;
  logic [2:0] burst_len;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    dir_d      = dir_q;
    up_d       = 1'b0;
    dw_d       = 1'b0;
    ld_d       = 1'b0;
    load_val_d = START_POS;
    issue      = 1'b0;
    hit        = 1'b0;
    limit      = dir_q ? at_min : at_max;
    burst_len  = (step_px == 3'd0) ? 3'd1 : step_px;

    case (state_q)
      // ld_q distinguishes the post-reset entry (pulse still owed) from a restart entry.
      S_LOAD: begin
        if (!ld_q) begin
          ld_d  = 1'b1;
          dir_d = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (enable && frame_tick) begin
          if (div_q == speed) begin
            div_d = '0;
            cnt_d = burst_len;
            if (limit) hit = 1'b1;
            else       issue = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      S_BURST: state_d = enable ? S_GAP : S_WAIT;
      S_GAP: begin
        if (limit)                         hit = 1'b1;
        else if (!enable || cnt_q == 3'd0) state_d = S_WAIT;
        else                               issue = 1'b1;
      end
      S_DWELL: begin
        if (enable && frame_tick) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            state_d = S_WAIT;
          end else begin
            dwell_d = dwell_q + DWC_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (issue) begin
      state_d = S_BURST;
      cnt_d   = cnt_d - 3'd1;
      up_d    = ~dir_q;
      dw_d    = dir_q;
    end

    // Terminal reached: reverse and drop whatever is left of the burst.
    if (hit) begin
      dir_d   = ~dir_q;
      cnt_d   = '0;
      dwell_d = '0;
      state_d = (DWELL_FRAMES == 0) ? S_WAIT : S_DWELL;
    end

    if (restart && state_q != S_LOAD) begin
      state_d = S_LOAD;
      ld_d    = 1'b1;
      dir_d   = 1'b0;
      div_d   = '0;
      cnt_d   = '0;
      dwell_d = '0;
      up_d    = 1'b0;
      dw_d    = 1'b0;
    end

    moving_d = (state_d == S_BURST) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      div_q      <= '0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      dir_q      <= 1'b0;
      up_q       <= 1'b0;
      dw_q       <= 1'b0;
      ld_q       <= 1'b0;
      moving_q   <= 1'b0;
      load_val_q <= START_POS;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      dir_q      <= dir_d;
      up_q       <= up_d;
      dw_q       <= dw_d;
      ld_q       <= ld_d;
      moving_q   <= moving_d;
      load_val_q <= load_val_d;
    end
  end

  assign UP       = up_q;
  assign DW       = dw_q;
  assign LD       = ld_q;
  assign load_val = load_val_q;
  assign dir      = dir_q;
  assign moving   = moving_q;

endmodule

// File: doc/hline_move_ctrl.md
Name: hline_move_ctrl

Overview:
- Sequencer for the horizontal-line position counter chain, which has UP/DW/LD controls and top/bottom terminal flags.
- Generates the counter's UP, DW and LD pulses. Makes the line bounce between the two terminal positions at a frame-paced, programmable speed, with edge dwell, pause and restart.
- Sits between the game-control logic and the line mover; drives the mover's control pins directly.

Parameters:
- START_POS, 16'd18, value driven on load_val for restart/reset loads.
- DWELL_FRAMES, 4, frames held at each edge before reversing; 0 means reverse immediately.
- DIV_W, 3, width of the speed divider input.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- frame_tick  input  1  one-cycle pulse per video frame.
- enable  input  1  1 = motion allowed; 0 = pause.
- restart  input  1  one-cycle request to reload START_POS and restart downward.
- speed  input  DIV_W  a step occurs every speed+1 frame_ticks.
- step_px  input  3  counter pulses per step; 0 is treated as 1.
- at_max  input  1  mover's upper terminal flag (Y == max).
- at_min  input  1  mover's lower terminal flag (Y == min).
- UP  output  1  one-cycle increment pulse to the mover.
- DW  output  1  one-cycle decrement pulse to the mover.
- LD  output  1  one-cycle load pulse to the mover.
- load_val  output  16  value for the mover's D input.
- dir  output  1  0 = incrementing, 1 = decrementing.
- moving  output  1  1 while a step burst is in progress.

Behaviour:
- All outputs are registered.
- Reset (asynchronous assert, synchronous deassert by design of the top):
  - UP, DW, LD, moving = 0; dir = 0; load_val = START_POS.
  - State goes to LOAD; frame divider, pulse and dwell counters are cleared.
- States: LOAD, WAIT, BURST, GAP, DWELL.
- LOAD:
  - LD = 1 for exactly one cycle with load_val = START_POS; dir := 0.
  - Next state is WAIT.
- WAIT:
  - Counts frame_ticks only while enable = 1.
  - When the divider reaches speed, the divider clears, the state goes to BURST and the pulse count is loaded with max(step_px, 1).
  - With speed = 0, every frame_tick starts a burst.
- BURST:
  - Issues one UP pulse (dir = 0) or one DW pulse (dir = 1); moving = 1.
  - Decrements the pulse count.
  - Next state is GAP.
- GAP:
  - One idle cycle so the terminal flag reflects the new position.
  - If the active limit is set (at_max when dir = 0, at_min when dir = 1): the burst ends, dir toggles, and the state goes to DWELL (or WAIT if DWELL_FRAMES = 0).
  - Otherwise, if the pulse count is 0, the state goes to WAIT.
  - Otherwise the state goes back to BURST.
- DWELL:
  - Counts DWELL_FRAMES frame_ticks; ticks are counted only while enable = 1.
  - Then goes to WAIT.
- Limit rules:
  - Never assert UP while at_max = 1, nor DW while at_min = 1.
  - If a burst starts already at the limit, issue no pulse, toggle dir and treat the cycle as a GAP hit.
- Pulse rules:
  - UP, DW and LD are mutually exclusive, one cycle wide.
  - Minimum spacing is 2 cycles between UP/DW pulses.
- Pause: enable = 0 during BURST/GAP lets the in-flight pulse complete, aborts the rest of the burst and returns to WAIT. The divider keeps its value.
- restart = 1 in any state goes to LOAD next cycle.
  - It overrides a same-cycle frame_tick, a pending pulse and enable.
  - A restart arriving in LOAD is absorbed (a single LD only).
- The frame divider is DIV_W bits and wraps naturally; changing speed mid-count takes effect at the next compare.

Test Plan:
1. Reset low 3 cycles, then release -> during reset UP=DW=LD=0 and load_val=18. In the first cycle after release, LD=1 for one cycle; then dir=0.
2. speed=2, step_px=1, enable=1, 9 frame_ticks -> exactly 3 UP pulses, each 1 cycle after the 3rd, 6th and 9th tick; no DW.
3. step_px=4, at_max rises after the 2nd pulse -> 2 UP pulses only. Then dir=1, 4 dwell frames with no pulses, and the next step gives DW pulses.
4. step_px=0, speed=0 -> 1 pulse per frame_tick, with pulses never closer than 2 cycles.
5. enable dropped in the GAP after the 1st pulse of a step_px=3 burst -> no further pulses while enable=0. After re-enable, the next burst starts on the divider's schedule.
6. restart coincident with a frame_tick mid-DWELL -> next cycle LD=1 with load_val=18 and dir=0, and no UP/DW in that cycle. A second restart during LOAD produces no second LD.
